issue_picker: RTL and testbench

ISSUE_PICKER -- requirements
Module: issue_picker

---
 rtl/issue_picker_pkg.sv | 26 ++
 rtl/pick_lowest4.sv | 18 +
 rtl/issue_picker.sv | 132 +++++++++++++
 tb/tb_issue_picker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_picker_pkg.sv
// ============================================================================
// Module      : issue_picker_pkg
// Description : Issue-window geometry, ROB tag width and pipe one-hot layout
//               shared by the issue queue and the issue picker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_picker_pkg;

  localparam int c_WIN_N     = 4;
  localparam int c_ROB_TAG_W = 4;
  localparam int c_PIPE_N    = 4;

  // Bit positions inside the one-hot pipe vector {bru,mem,mul,alu}
  localparam int c_PIPE_ALU  = 0;
  localparam int c_PIPE_MUL  = 1;
  localparam int c_PIPE_MEM  = 2;
  localparam int c_PIPE_BRU  = 3;

  typedef logic [c_PIPE_N-1:0]    pipe_t;
  typedef logic [c_ROB_TAG_W-1:0] rob_tag_t;

endpackage

`default_nettype wire

// File: rtl/pick_lowest4.sv
// ============================================================================
// Module      : pick_lowest4
// Description : 4-bit priority encoder returning the lowest set bit one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pick_lowest4 (
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  // Two's-complement trick isolates the least significant set bit.
  assign gnt = req & (~req + 4'd1);

endmodule

`default_nettype wire

// File: rtl/issue_picker.sv
// ============================================================================
// Module      : issue_picker
// Description : Picks the oldest eligible window entry into a one-deep issue
//               slot, honouring in-order mem/bru and multiplier occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_picker
  import issue_picker_pkg::*;
#(
  parameter int PAYLOAD_W = 160,
  parameter int MUL_BUSY  = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           bco_valid,
  input  logic [c_WIN_N-1:0]             win_valid,
  input  logic [c_WIN_N-1:0]             win_src0_rdy,
  input  logic [c_WIN_N-1:0]             win_src1_rdy,
  input  logic [c_WIN_N-1:0]             win_pipe_alu,
  input  logic [c_WIN_N-1:0]             win_pipe_mul,
  input  logic [c_WIN_N-1:0]             win_pipe_mem,
  input  logic [c_WIN_N-1:0]             win_pipe_bru,
  input  logic [c_WIN_N*c_ROB_TAG_W-1:0] win_dst_rob,
  input  logic [c_WIN_N*PAYLOAD_W-1:0]   win_payload,
  output logic [c_WIN_N-1:0]             wed,
  output logic                           iss_valid,
  output logic [c_PIPE_N-1:0]            iss_pipe,
  output logic [c_ROB_TAG_W-1:0]         iss_dst_rob,
  output logic [PAYLOAD_W-1:0]           iss_payload,
  input  logic                           iss_ready
);

  localparam int                c_CNT_W    = $clog2(MUL_BUSY + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_BUSY);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0]     r_mul_cnt;
  logic [c_WIN_N-1:0]     w_mem_oldest;
  logic [c_WIN_N-1:0]     w_bru_oldest;
  logic [c_WIN_N-1:0]     w_permit;
  logic [c_WIN_N-1:0]     w_elig;
  logic [c_WIN_N-1:0]     w_pick;
  logic                   w_fire;
  logic                   w_slot_free;
  logic                   w_mul_picked;
  pipe_t                  w_sel_pipe;
  rob_tag_t               w_sel_dst;
  logic [PAYLOAD_W-1:0]   w_sel_payload;

  pick_lowest4 u_mem_oldest (
    .req (win_valid & win_pipe_mem),
    .gnt (w_mem_oldest)
  );

  pick_lowest4 u_bru_oldest (
    .req (win_valid & win_pipe_bru),
    .gnt (w_bru_oldest)
  );

  assign w_permit = win_pipe_alu
                  | (win_pipe_mul & {c_WIN_N{r_mul_cnt == '0}})
                  | (win_pipe_mem & w_mem_oldest)
                  | (win_pipe_bru & w_bru_oldest);

  // Reset and flush are folded in here so wed is quiet in both cases.
  assign w_elig = win_valid & win_src0_rdy & win_src1_rdy & w_permit
                & {c_WIN_N{~bco_valid & resetn}};

  pick_lowest4 u_elig_pick (
    .req (w_elig),
    .gnt (w_pick)
  );

  assign w_fire       = iss_valid & iss_ready;
  assign w_slot_free  = ~iss_valid | w_fire;
  assign wed          = w_slot_free ? w_pick : '0;
  assign w_mul_picked = |(wed & win_pipe_mul);

  always_comb begin
    w_sel_pipe    = '0;
    w_sel_dst     = '0;
    w_sel_payload = '0;
    for (int i = 0; i < c_WIN_N; i++) begin
      if (w_pick[i]) begin
        w_sel_pipe[c_PIPE_ALU] = win_pipe_alu[i];
        w_sel_pipe[c_PIPE_MUL] = win_pipe_mul[i];
        w_sel_pipe[c_PIPE_MEM] = win_pipe_mem[i];
        w_sel_pipe[c_PIPE_BRU] = win_pipe_bru[i];
        w_sel_dst              = win_dst_rob[i*c_ROB_TAG_W +: c_ROB_TAG_W];
        w_sel_payload          = win_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Counter keeps running through a flush: the multiplier is still busy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mul_cnt <= '0;
    end else if (w_mul_picked) begin
      r_mul_cnt <= c_MUL_LOAD;
    end else if (r_mul_cnt != '0) begin
      r_mul_cnt <= r_mul_cnt - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iss_valid   <= 1'b0;
      iss_pipe    <= '0;
      iss_dst_rob <= '0;
    end else if (bco_valid) begin
      iss_valid   <= 1'b0;
    end else if (|wed) begin
      iss_valid   <= 1'b1;
      iss_pipe    <= w_sel_pipe;
      iss_dst_rob <= w_sel_dst;
    end else if (w_fire) begin
      iss_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (|wed) begin
      iss_payload <= w_sel_payload;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_picker.sv
// ============================================================================
// Module      : tb_issue_picker
// Description : Self-checking bench for issue_picker: directed scenarios plus
//               randomized window traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_picker;

  localparam int PW  = 160;
  localparam int MB  = 3;
  localparam int ALU = 0;
  localparam int MUL = 1;
  localparam int MEM = 2;
  localparam int BRU = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            bco_valid;
  logic [3:0]      win_valid, win_src0_rdy, win_src1_rdy;
  logic [3:0]      win_pipe_alu, win_pipe_mul, win_pipe_mem, win_pipe_bru;
  logic [15:0]     win_dst_rob;
  logic [4*PW-1:0] win_payload;
  logic [3:0]      wed;
  logic            iss_valid;
  logic [3:0]      iss_pipe;
  logic [3:0]      iss_dst_rob;
  logic [PW-1:0]   iss_payload;
  logic            iss_ready;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: what the issue slot holds and when the last mul left.
  bit            m_valid   = 1'b0;
  bit            m_zeroed  = 1'b1;
  logic [3:0]    m_pipe    = '0;
  logic [3:0]    m_dst     = '0;
  logic [PW-1:0] m_payload = '0;
  int            m_last_mul = -1000;
  int            cyc = 0;

  issue_picker #(.PAYLOAD_W(PW), .MUL_BUSY(MB)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bco_valid    (bco_valid),
    .win_valid    (win_valid),
    .win_src0_rdy (win_src0_rdy),
    .win_src1_rdy (win_src1_rdy),
    .win_pipe_alu (win_pipe_alu),
    .win_pipe_mul (win_pipe_mul),
    .win_pipe_mem (win_pipe_mem),
    .win_pipe_bru (win_pipe_bru),
    .win_dst_rob  (win_dst_rob),
    .win_payload  (win_payload),
    .wed          (wed),
    .iss_valid    (iss_valid),
    .iss_pipe     (iss_pipe),
    .iss_dst_rob  (iss_dst_rob),
    .iss_payload  (iss_payload),
    .iss_ready    (iss_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Index of the entry the picker must choose this cycle, or -1.
  function automatic int model_pick();
    int  mem_old;
    int  bru_old;
    bit  mul_ok;
    bit  ok;
    mem_old = -1;
    bru_old = -1;
    if (!resetn || bco_valid) return -1;
    if (m_valid && !iss_ready) return -1;
    for (int i = 0; i < 4; i++) begin
      if (win_valid[i] && win_pipe_mem[i] && mem_old < 0) mem_old = i;
      if (win_valid[i] && win_pipe_bru[i] && bru_old < 0) bru_old = i;
    end
    mul_ok = (cyc - m_last_mul) > MB;
    for (int i = 0; i < 4; i++) begin
      if (win_valid[i] && win_src0_rdy[i] && win_src1_rdy[i]) begin
        if (win_pipe_alu[i])      ok = 1'b1;
        else if (win_pipe_mul[i]) ok = mul_ok;
        else if (win_pipe_mem[i]) ok = (i == mem_old);
        else if (win_pipe_bru[i]) ok = (i == bru_old);
        else                      ok = 1'b0;
        if (ok) return i;
      end
    end
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    int         p;
    logic [3:0] exp_wed;
    p       = model_pick();
    exp_wed = '0;
    if (p >= 0) exp_wed[p] = 1'b1;
    check("wed", wed, exp_wed);
    check("iss_valid", iss_valid, m_valid);
    if (m_valid || m_zeroed) begin
      check("iss_pipe", iss_pipe, m_pipe);
      check("iss_dst_rob", iss_dst_rob, m_dst);
    end
    if (m_valid) check("iss_payload", iss_payload, m_payload);
    if (!resetn) begin
      m_valid    = 1'b0;
      m_zeroed   = 1'b1;
      m_pipe     = '0;
      m_dst      = '0;
      m_last_mul = -1000;
    end else if (bco_valid) begin
      m_valid = 1'b0;
    end else if (p >= 0) begin
      m_valid   = 1'b1;
      m_zeroed  = 1'b0;
      m_pipe    = {win_pipe_bru[p], win_pipe_mem[p], win_pipe_mul[p], win_pipe_alu[p]};
      m_dst     = win_dst_rob[p*4 +: 4];
      m_payload = win_payload[p*PW +: PW];
      if (win_pipe_mul[p]) m_last_mul = cyc;
    end else if (m_valid && iss_ready) begin
      m_valid = 1'b0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_win();
    win_valid    = '0;
    win_src0_rdy = '0;
    win_src1_rdy = '0;
    win_pipe_alu = '0;
    win_pipe_mul = '0;
    win_pipe_mem = '0;
    win_pipe_bru = '0;
  endtask

  task automatic set_e(input int i, input bit r0, input bit r1, input int pipe, input logic [3:0] tag);
    win_valid[i]    = 1'b1;
    win_src0_rdy[i] = r0;
    win_src1_rdy[i] = r1;
    win_pipe_alu[i] = (pipe == ALU);
    win_pipe_mul[i] = (pipe == MUL);
    win_pipe_mem[i] = (pipe == MEM);
    win_pipe_bru[i] = (pipe == BRU);
    win_dst_rob[i*4 +: 4] = tag;
    for (int w = 0; w < PW/32; w++) win_payload[i*PW + w*32 +: 32] = $urandom();
  endtask

  initial begin
    resetn      = 1'b0;
    bco_valid   = 1'b0;
    iss_ready   = 1'b1;
    win_dst_rob = '0;
    win_payload = '0;
    clear_win();
    repeat (3) step();

    // Two ready alu entries: lowest index wins, tag appears one cycle later
    resetn = 1'b1;
    set_e(1, 1, 1, ALU, 4'h5);
    set_e(2, 1, 1, ALU, 4'h9);
    #3 check("d_alu_wed", wed, 4'b0010);
    step();
    clear_win();
    #3 check("d_alu_valid", iss_valid, 1'b1);
    check("d_alu_dst", iss_dst_rob, 4'h5);
    step();

    // Older mem not ready blocks the younger one
    set_e(0, 0, 1, MEM, 4'h1);
    set_e(1, 1, 1, MEM, 4'h2);
    #3 check("d_mem_block", wed, 4'b0000);
    step();
    win_src0_rdy[0] = 1'b1;
    #3 check("d_mem_go", wed, 4'b0001);
    step();
    clear_win();
    step();

    // Back-to-back muls are spaced by the busy window
    set_e(0, 1, 1, MUL, 4'h3);
    set_e(1, 1, 1, MUL, 4'h4);
    #3 check("d_mul_first", wed, 4'b0001);
    step();
    clear_win();
    set_e(0, 1, 1, MUL, 4'h4);
    for (int k = 0; k < 3; k++) begin
      #3 check("d_mul_busy", wed, 4'b0000);
      step();
    end
    #3 check("d_mul_second", wed, 4'b0001);
    step();
    clear_win();
    step();

    // Stall holds the slot, release fires and reloads in the same cycle
    set_e(0, 1, 1, ALU, 4'h6);
    #3 check("d_stall_load", wed, 4'b0001);
    step();
    iss_ready = 1'b0;
    set_e(0, 1, 1, ALU, 4'h7);
    set_e(1, 1, 1, ALU, 4'h8);
    for (int k = 0; k < 4; k++) begin
      #3 check("d_stall_wed", wed, 4'b0000);
      check("d_stall_dst", iss_dst_rob, 4'h6);
      check("d_stall_valid", iss_valid, 1'b1);
      step();
    end
    iss_ready = 1'b1;
    #3 check("d_release_wed", wed, 4'b0001);
    step();
    #3 check("d_reload_dst", iss_dst_rob, 4'h7);
    check("d_reload_valid", iss_valid, 1'b1);

    // Flush during a stall empties the slot
    step();
    iss_ready = 1'b0;
    bco_valid = 1'b1;
    #3 check("d_bco_wed", wed, 4'b0000);
    step();
    bco_valid = 1'b0;
    #3 check("d_bco_valid", iss_valid, 1'b0);
    step();
    clear_win();
    iss_ready = 1'b1;
    step();
    step();

    // Reset while the multiplier is busy frees it at once
    set_e(0, 1, 1, MUL, 4'hA);
    #3 check("d_rst_mulpick", wed, 4'b0001);
    step();
    iss_ready = 1'b0;
    set_e(0, 1, 1, MUL, 4'hB);
    step();
    resetn = 1'b0;
    #3 check("d_rst_wed", wed, 4'b0000);
    step();
    resetn = 1'b1;
    #3 check("d_rst_valid", iss_valid, 1'b0);
    check("d_rst_mulfree", wed, 4'b0001);
    step();

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 1500; n++) begin
      resetn    = ($urandom_range(0, 63) != 0);
      bco_valid = ($urandom_range(0, 15) == 0);
      iss_ready = ($urandom_range(0, 3) != 0);
      clear_win();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) != 0)
          set_e(i, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end
      step();
    end

    clear_win();
    resetn    = 1'b1;
    bco_valid = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
